mul_share_arbiter: RTL and testbench

- Shares one multi-cycle shift-add multiplier (`r2_shift_add_mul`-style port set: `Xin`, `Yin`, `i_valid`, `Zout`, `o_valid`) between NREQ requesters.
- Arbitrates with a round-robin policy and sequences a single operation at a time: issue, then wait for the result, then return it.
- Returns the tagged product, with a watchdog timeout that flags a multiplier that never answers.
- Sits between the client blocks and the multiplier instance. The multiplier is not instantiated inside this block.

---
 rtl/mul_share_pkg.sv | 28 ++
 rtl/mul_share_arbiter_rr.sv | 49 ++++
 rtl/mul_share_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mul_share_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_share_pkg
//  Description : Shared types and default sizing for the multiplier-sharing
//                arbiter. Holds the sequencer state encoding and the derived
//                widths that match the default DWIDTH/NREQ/TIMEOUT.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_share_pkg;

  // Sequencer states: one operation in flight at a time.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // Default sizing and the widths derived from it.
  localparam int DEF_DWIDTH  = 4;
  localparam int DEF_NREQ    = 4;
  localparam int DEF_TIMEOUT = 31;
  localparam int DEF_OWIDTH  = 2 * DEF_DWIDTH;
  localparam int DEF_IDW     = $clog2(DEF_NREQ);
  localparam int DEF_TW      = $clog2(DEF_TIMEOUT + 1);

endpackage
`default_nettype wire

// File: rtl/mul_share_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Purely combinational round-robin picker. Searches req starting
//                at index ptr and wrapping; the first set bit wins.
//  Ports       : req      [NREQ]  request vector
//                ptr      [IDW]   index given highest priority (must be < NREQ)
//                grant    [NREQ]  one-hot grant (all zero when no request)
//                grant_id [IDW]   index of the granted requester
//                any      [1]     at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            any
);

  // One extra bit so ptr + offset can be wrapped without overflow.
  logic [IDW:0] sum;
  logic [IDW-1:0] idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr} + (IDW+1)'(k);
      if (sum >= (IDW+1)'(NREQ)) begin
        sum = sum - (IDW+1)'(NREQ);
      end
      idx = sum[IDW-1:0];
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/mul_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mul_share_arbiter
//  Description : Shares one multi-cycle multiplier between NREQ requesters.
//                Round-robin grant, then ISSUE -> WAIT -> RESP for a single
//                operation; a watchdog turns a silent multiplier into an error
//                response after TIMEOUT WAIT cycles.
//  Ports       : clk, rst (async, active-high)
//                req_valid/req_ready [NREQ], req_x/req_y [NREQ*DWIDTH]
//                rsp_valid/rsp_ready, rsp_id [IDW], rsp_z [OWIDTH], rsp_err
//                mul_i_valid, mul_xin, mul_yin -> multiplier inputs
//                mul_zout, mul_o_valid         <- multiplier outputs
//                busy: high whenever the sequencer is not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_share_arbiter
  import mul_share_pkg::*;
#(
  parameter  int DWIDTH  = 4,
  parameter  int NREQ    = 4,
  parameter  int TIMEOUT = 31,
  localparam int OWIDTH  = 2 * DWIDTH,
  localparam int IDW     = $clog2(NREQ),
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*DWIDTH-1:0] req_x,
  input  logic [NREQ*DWIDTH-1:0] req_y,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [OWIDTH-1:0]      rsp_z,
  output logic                   rsp_err,
  output logic                   mul_i_valid,
  output logic [DWIDTH-1:0]      mul_xin,
  output logic [DWIDTH-1:0]      mul_yin,
  input  logic [OWIDTH-1:0]      mul_zout,
  input  logic                   mul_o_valid,
  output logic                   busy
);

  state_t              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [DWIDTH-1:0]   x_q, x_d;
  logic [DWIDTH-1:0]   y_q, y_d;
  logic [IDW-1:0]      id_q, id_d;
  logic [OWIDTH-1:0]   z_q, z_d;
  logic                err_q, err_d;
  logic                mul_i_valid_q, mul_i_valid_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                busy_q, busy_d;

  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      grant_id;
  logic                grant_any;

  // Per-requester operand views of the packed buses.
  logic [DWIDTH-1:0]   x_arr [NREQ];
  logic [DWIDTH-1:0]   y_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign x_arr[gi] = req_x[gi*DWIDTH +: DWIDTH];
    assign y_arr[gi] = req_y[gi*DWIDTH +: DWIDTH];
  end

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_rr (
    .req      (req_valid),
    .ptr      (ptr_q),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (grant_any)
  );

  // Grant is only offered while idle; reset forces it low even though the
  // state register already reads IDLE.
  assign req_ready   = (state_q == IDLE && !rst) ? grant : '0;
  assign mul_i_valid = mul_i_valid_q;
  assign mul_xin     = x_q;
  assign mul_yin     = y_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = id_q;
  assign rsp_z       = z_q;
  assign rsp_err     = err_q;
  assign busy        = busy_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    timer_d = timer_q;
    x_d     = x_q;
    y_d     = y_q;
    id_d    = id_q;
    z_d     = z_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          x_d     = x_arr[grant_id];
          y_d     = y_arr[grant_id];
          id_d    = grant_id;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        timer_d = timer_q + 1'b1;
        // A result arriving on the last allowed cycle still beats the watchdog.
        if (mul_o_valid) begin
          z_d     = mul_zout;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          z_d     = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          ptr_d   = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    mul_i_valid_d = (state_d == ISSUE);
    rsp_valid_d   = (state_d == RESP);
    busy_d        = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ptr_q         <= '0;
      timer_q       <= '0;
      x_q           <= '0;
      y_q           <= '0;
      id_q          <= '0;
      z_q           <= '0;
      err_q         <= 1'b0;
      mul_i_valid_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      timer_q       <= timer_d;
      x_q           <= x_d;
      y_q           <= y_d;
      id_q          <= id_d;
      z_q           <= z_d;
      err_q         <= err_d;
      mul_i_valid_q <= mul_i_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      busy_q        <= busy_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_share_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_share_arbiter
//  Description : Self-checking bench for mul_share_arbiter. A cycle-level
//                transaction model predicts grants, issue timing, responses
//                and timeouts; directed tables and sequences add fixed
//                expectations on top.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_share_arbiter;

  localparam int DWIDTH  = 4;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 31;
  localparam int OWIDTH  = 2 * DWIDTH;
  localparam int IDW     = 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid, req_ready;
  logic [NREQ*DWIDTH-1:0] req_x, req_y;
  logic                   rsp_valid, rsp_ready, rsp_err;
  logic [IDW-1:0]         rsp_id;
  logic [OWIDTH-1:0]      rsp_z;
  logic                   mul_i_valid, mul_o_valid, busy;
  logic [DWIDTH-1:0]      mul_xin, mul_yin;
  logic [OWIDTH-1:0]      mul_zout;
  logic                   mdl_ov, stray_ov;

  assign mul_o_valid = mdl_ov | stray_ov;

  always #5 clk = ~clk;

  mul_share_arbiter #(.DWIDTH(DWIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_z(rsp_z), .rsp_err(rsp_err),
    .mul_i_valid(mul_i_valid), .mul_xin(mul_xin), .mul_yin(mul_yin),
    .mul_zout(mul_zout), .mul_o_valid(mul_o_valid), .busy(busy)
  );

  typedef struct { int id; int z; int err; int gcyc; int rcyc; } rsp_rec_t;
  typedef struct { int id; int x; int y; int lat; int exp_z; int exp_dly; } vec_t;

  int n_cmp, n_bad, cyc, n_done;
  // requester side
  int pend_cnt [NREQ];
  int pend_x   [NREQ];
  int pend_y   [NREQ];
  bit rand_ops, rand_valid, rand_lat;
  int rdy_mode;               // 0: always ready, 1: random, 2: held low
  // multiplier stand-in
  int mdl_lat, mdl_rem;
  bit mdl_never;
  logic [OWIDTH-1:0] mdl_prod;
  // transaction model
  bit m_busy;
  int m_ptr, m_id, m_x, m_y, m_tg, m_rc, m_z, m_err, act_first;
  int glog[$];
  rsp_rec_t rlog[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] v, input int p);
    logic [NREQ-1:0] r;
    r = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) begin
        r[(p + k) % NREQ] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (pend_cnt[i] > 0) && (!rand_valid || $urandom_range(0, 3) != 0);
      req_x[i*DWIDTH +: DWIDTH] = DWIDTH'(pend_x[i]);
      req_y[i*DWIDTH +: DWIDTH] = DWIDTH'(pend_y[i]);
    end
    rsp_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // Compare this cycle's outputs with the model, then advance the model.
  task automatic check_cycle();
    logic [NREQ-1:0] exp_rdy;
    bit exp_iv, exp_rv;
    int g;
    if (rst) begin
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mul_i_valid", mul_i_valid, 0);
      chk("rst_operands", {mul_xin, mul_yin}, 0);
      chk("rst_rsp_fields", {rsp_id, rsp_z, rsp_err}, 0);
      m_busy = 1'b0;
      m_ptr  = 0;
      return;
    end
    exp_rdy = m_busy ? '0 : rr_pick(req_valid, m_ptr);
    chk("req_ready", req_ready, exp_rdy);
    chk("busy", busy, m_busy);
    exp_iv = m_busy && (cyc == m_tg + 1);
    chk("mul_i_valid", mul_i_valid, exp_iv);
    if (exp_iv) begin
      chk("mul_xin", mul_xin, m_x);
      chk("mul_yin", mul_yin, m_y);
    end
    exp_rv = m_busy && (m_rc >= 0) && (cyc >= m_rc);
    chk("rsp_valid", rsp_valid, exp_rv);
    if (rsp_valid && act_first < 0) act_first = cyc;
    if (exp_rv) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_z", rsp_z, m_z);
      chk("rsp_err", rsp_err, m_err);
    end
    for (int i = 0; i < NREQ; i++) if (req_ready[i]) glog.push_back(i);

    if (!m_busy) begin
      if (exp_rdy != '0) begin
        g = 0;
        for (int i = 0; i < NREQ; i++) if (exp_rdy[i]) g = i;
        m_busy = 1'b1; m_id = g; m_x = pend_x[g]; m_y = pend_y[g];
        m_tg = cyc; m_rc = -1; act_first = -1;
        pend_cnt[g]--;
        if (rand_ops) begin
          pend_x[g] = $urandom_range(0, 15);
          pend_y[g] = $urandom_range(0, 15);
        end
      end
    end else if (exp_rv) begin
      if (rsp_ready) begin
        rlog.push_back('{int'(rsp_id), int'(rsp_z), int'(rsp_err), m_tg, act_first});
        m_busy = 1'b0;
        m_ptr  = (m_id + 1) % NREQ;
        n_done++;
      end
    end else if (m_rc < 0 && cyc >= m_tg + 2) begin
      if (mul_o_valid) begin
        m_rc = cyc + 1; m_z = m_x * m_y; m_err = 0;
      end else if (cyc == m_tg + 1 + TIMEOUT) begin
        m_rc = cyc + 1; m_z = 0; m_err = 1;
      end
    end
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic tick();
    drive_inputs();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    cyc++;
    #1;
    mdl_ov   = 1'b0;
    mul_zout = OWIDTH'($urandom);
    if (rst) begin
      mdl_rem = 0;
    end else begin
      if (mdl_rem > 0) begin
        mdl_rem--;
        if (mdl_rem == 0) begin
          mdl_ov   = 1'b1;
          mul_zout = mdl_prod;
        end
      end
      if (mul_i_valid) begin
        if (rand_lat) begin
          mdl_lat   = $urandom_range(1, 12);
          mdl_never = ($urandom_range(0, 7) == 0);
        end
        mdl_prod = OWIDTH'(mul_xin) * OWIDTH'(mul_yin);
        mdl_rem  = mdl_never ? 0 : mdl_lat;
      end
    end
  endtask

  task automatic run_until(input int target, input int budget, input string name);
    int k;
    k = 0;
    while (n_done < target && k < budget) begin
      tick();
      k++;
    end
    chk(name, n_done >= target, 1);
  endtask

  task automatic post(input int id, input int x, input int y, input int cnt);
    pend_x[id] = x; pend_y[id] = y; pend_cnt[id] = cnt;
  endtask

  vec_t tbl[6];
  rsp_rec_t r;

  initial begin
    int base, k, sum;
    n_cmp = 0; n_bad = 0; cyc = 0; n_done = 0;
    rst = 1'b1; stray_ov = 1'b0; mdl_ov = 1'b0; mul_zout = '0;
    rand_ops = 0; rand_valid = 0; rand_lat = 0; rdy_mode = 0;
    mdl_lat = 4; mdl_never = 0; mdl_rem = 0; mdl_prod = '0;
    m_busy = 0; m_ptr = 0; act_first = -1;
    for (int i = 0; i < NREQ; i++) post(i, 0, 0, 0);
    req_valid = '0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // All four requesters right after reset: grants 0,1,2,3
    mdl_lat = 3;
    for (int i = 0; i < NREQ; i++) post(i, i + 1, 15, 1);
    glog.delete(); base = rlog.size();
    run_until(n_done + 4, 200, "t2_done");
    chk("t2_grant_count", glog.size(), 4);
    for (int i = 0; i < 4 && i < glog.size(); i++) begin
      chk("t2_grant_order", glog[i], i);
      chk("t2_rsp_z", rlog[base + i].z, 15 * (i + 1));
    end

    // Table of single requests: {id, x, y, latency, product, grant->rsp delay}
    tbl = '{'{0, 2, 3, 4, 6, 6}, '{2, 15, 15, 2, 225, 4}, '{1, 0, 9, 1, 0, 3},
            '{3, 7, 8, 7, 56, 9}, '{1, 15, 1, 3, 15, 5}, '{0, 9, 13, 5, 117, 7}};
    foreach (tbl[v]) begin
      mdl_lat = tbl[v].lat;
      post(tbl[v].id, tbl[v].x, tbl[v].y, 1);
      run_until(n_done + 1, 100, "tbl_done");
      r = rlog[$];
      chk("tbl_rsp_id", r.id, tbl[v].id);
      chk("tbl_rsp_z", r.z, tbl[v].exp_z);
      chk("tbl_rsp_err", r.err, 0);
      chk("tbl_rsp_delay", r.rcyc - r.gcyc, tbl[v].exp_dly);
    end

    // Requesters 1 and 3 held: strict alternation from pointer 1
    mdl_lat = 2;
    post(1, 3, 5, 6); post(3, 11, 2, 6);
    glog.delete();
    run_until(n_done + 12, 300, "t3_done");
    chk("t3_grant_count", glog.size(), 12);
    for (int i = 0; i < 12 && i < glog.size(); i++)
      chk("t3_alternate", glog[i], (i % 2 == 0) ? 1 : 3);

    // Response back-pressure for 5 cycles
    rdy_mode = 2;
    post(0, 6, 7, 1); post(2, 4, 4, 1);
    k = 0;
    while (!rsp_valid && k < 40) begin tick(); k++; end
    chk("t4_rsp_seen", rsp_valid, 1);
    repeat (5) begin
      tick();
      chk("t4_hold_valid", rsp_valid, 1);
      chk("t4_hold_z", rsp_z, 42);
      chk("t4_hold_id", rsp_id, 0);
      chk("t4_no_ready", req_ready, 0);
      chk("t4_no_issue", mul_i_valid, 0);
    end
    rdy_mode = 0;
    base = rlog.size();
    run_until(n_done + 2, 100, "t4_done");
    chk("t4_z0", rlog[base].z, 42);
    chk("t4_z1", rlog[base + 1].z, 16);

    // Watchdog: silent multiplier, result on the last allowed cycle, one late
    mdl_never = 1;
    post(1, 9, 9, 1);
    run_until(n_done + 1, 80, "t5_to_done");
    r = rlog[$];
    chk("t5_to_err", r.err, 1);
    chk("t5_to_z", r.z, 0);
    chk("t5_to_delay", r.rcyc - r.gcyc, 33);
    mdl_never = 0; mdl_lat = 31;
    post(2, 13, 11, 1);
    run_until(n_done + 1, 80, "t5_edge_done");
    r = rlog[$];
    chk("t5_edge_err", r.err, 0);
    chk("t5_edge_z", r.z, 143);
    chk("t5_edge_delay", r.rcyc - r.gcyc, 33);
    mdl_lat = 32;
    post(3, 3, 3, 1);
    run_until(n_done + 1, 80, "t5_late_done");
    r = rlog[$];
    chk("t5_late_err", r.err, 1);
    chk("t5_late_z", r.z, 0);
    repeat (4) tick();

    // Randomized traffic against the model
    rand_ops = 1; rand_valid = 1; rand_lat = 1; rdy_mode = 1;
    for (int i = 0; i < NREQ; i++) post(i, $urandom_range(0, 15), $urandom_range(0, 15), 40);
    run_until(n_done + 160, 20000, "rand_done");
    sum = 0;
    for (int i = 0; i < NREQ; i++) sum += pend_cnt[i];
    chk("rand_all_served", sum, 0);
    rand_ops = 0; rand_valid = 0; rand_lat = 0; rdy_mode = 0;
    mdl_never = 0; mdl_lat = 20;
    repeat (2) tick();

    // Reset in WAIT, stray o_valid in IDLE, then a fresh request from pointer 0
    post(3, 2, 2, 1);
    k = 0;
    while (!mul_i_valid && k < 20) begin tick(); k++; end
    chk("t6_issued", mul_i_valid, 1);
    repeat (3) tick();
    chk("t6_in_wait", busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_async_busy", busy, 0);
    chk("t6_async_outs", {rsp_valid, mul_i_valid, req_ready}, 0);
    chk("t6_async_regs", {mul_xin, mul_yin, rsp_id, rsp_z, rsp_err}, 0);
    repeat (2) tick();
    rst = 1'b0;
    stray_ov = 1'b1;
    tick();
    stray_ov = 1'b0;
    tick();
    chk("t6_stray_busy", busy, 0);
    chk("t6_stray_rsp", rsp_valid, 0);
    mdl_lat = 3;
    for (int i = 0; i < NREQ; i++) post(i, 5, 7, 1);
    run_until(n_done + 1, 60, "t6_done");
    r = rlog[$];
    chk("t6_rsp_id", r.id, 0);
    chk("t6_rsp_z", r.z, 35);
    run_until(n_done + 3, 100, "t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
